// File: rtl/eq_pkg.sv
// Shared EQ definitions used by the coefficient SPI paths.
//   coeff_t          : one signed 16-bit filter coefficient
//   NUM_EQ_COEFFS    : active coefficients, three bands of b0,b1,b2,a1,a2
//   READBACK_HEADER  : first word of every readback frame
//   readback_state_t : state of the readback transmitter
package eq_pkg;

  typedef logic signed [15:0] coeff_t;

  localparam int NUM_EQ_COEFFS = 15;
  localparam logic [15:0] READBACK_HEADER = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } readback_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings one asynchronous SPI pin into the system clock domain and derives
// single-cycle rise/fall pulses from the synchronized copy.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : synchronous active-low reset
//   i_async  : asynchronous pin (sck or cs)
//   o_sync   : synchronized level (last synchronizer stage)
//   o_rise   : 1-cycle pulse on a synchronized 0->1 transition
//   o_fall   : 1-cycle pulse on a synchronized 1->0 transition
// The chain resets to 0 so that a pin already low when reset releases does
// not produce a falling edge; only a later genuine high->low transition does.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_readback_tx.sv
// SPI-slave transmit path: while the MCU holds cs low, shifts out on sdo a
// frame of 16-bit words {HEADER, peak |sample| since the previous frame,
// coefficient words 0..NUM_COEFFS-1}. SPI mode 0, MSB first; sck and cs are
// oversampled in the clk_in domain (sck period >= 8 clk_in periods).
// Ports:
//   clk_in       : system clock
//   rst_in       : synchronous active-low reset
//   sck, cs      : SPI clock / active-low chip select from the MCU (async)
//   sample       : signed audio sample, sample_valid marks a new one
//   coeff_flat   : coefficients, word 0 in [15:0]; read only when a frame starts
//   sdo, sdo_oe  : serial data and its pad output enable
//   busy         : frame in progress (not IDLE)
//   frame_done   : 1-cycle pulse when cs releases after the full frame
// Handshake: there is no valid/ready pair; a frame is framed by cs alone.
// cs low starts it, each synchronized sck falling edge advances one bit, and
// cs high ends it at any point (taking priority over a same-cycle sck edge).
module spi_readback_tx
  import eq_pkg::*;
#(
  parameter int          NUM_COEFFS  = NUM_EQ_COEFFS,
  parameter logic [15:0] HEADER      = READBACK_HEADER,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sck,
  input  logic                    cs,
  input  logic [15:0]             sample,
  input  logic                    sample_valid,
  input  logic [NUM_COEFFS*16-1:0] coeff_flat,
  output logic                    sdo,
  output logic                    sdo_oe,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int FRAME_BITS = (NUM_COEFFS + 2) * 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS);

  readback_state_t r_state;
  readback_state_t w_next;

  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CNT_W-1:0]      r_cnt;
  logic [15:0]           r_peak;
  logic [15:0]           w_abs;
  logic                  r_frame_done;

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_unused_edges;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_async (sck),
    .o_sync  (w_sck_lvl),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_async (cs),
    .o_sync  (w_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // The MCU samples on sck rising edges, so only falling edges matter here;
  // cs is used as a level, not as a rising edge.
  assign w_unused_edges = w_sck_lvl & w_sck_rise & w_cs_rise;

  // Magnitude of the sample; -32768 has no positive twin so it clamps.
  always_comb begin
    w_abs = sample;
    if (sample[15]) begin
      w_abs = (sample == 16'h8000) ? 16'h7FFF : (~sample + 16'd1);
    end
  end

  // Frame image, word 0 (HEADER) in the MSBs so it leaves first.
  always_comb begin
    w_frame = '0;
    w_frame[FRAME_BITS-1 -: 16]  = HEADER;
    w_frame[FRAME_BITS-17 -: 16] = r_peak;
    for (int i = 0; i < NUM_COEFFS; i++) begin
      w_frame[FRAME_BITS-33-16*i -: 16] = coeff_flat[16*i +: 16];
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state. A released cs ends any frame, complete or not.
  always_comb begin
    w_next = r_state;
    if (r_state != IDLE && w_cs_lvl) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall) w_next = LOAD;
        LOAD:    w_next = SHIFT;
        SHIFT:   if (r_cnt == CNT_MAX) w_next = DONE;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    sdo    = 1'b0;
    sdo_oe = 1'b0;
    busy   = 1'b0;
    case (r_state)
      LOAD: begin
        // The shift register loads at the end of this cycle; drive the
        // first bit directly so sdo is valid as early as possible.
        sdo    = HEADER[15];
        sdo_oe = 1'b1;
        busy   = 1'b1;
      end
      SHIFT: begin
        sdo    = r_shift[FRAME_BITS-1];
        sdo_oe = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        sdo_oe = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_done = r_frame_done;

  // Datapath: shift register, bit counter, peak tracker, done pulse
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_peak       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == DONE) && (w_next == IDLE);

      if (r_state == LOAD) begin
        r_shift <= w_frame;
        r_cnt   <= '0;
      end else if (r_state == SHIFT && w_sck_fall && !w_cs_lvl &&
                   r_cnt != CNT_MAX) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        r_cnt   <= r_cnt + 1'b1;
      end

      // The snapshot above took the old peak; a sample arriving in LOAD
      // belongs to the next frame.
      if (r_state == LOAD) begin
        r_peak <= sample_valid ? w_abs : 16'h0000;
      end else if (sample_valid && (w_abs > r_peak)) begin
        r_peak <= w_abs;
      end
    end
  end

endmodule
